// File: rtl/mc_ctrl_pkg.sv
// Shared encodings, instruction class and FSM state type for the multi-cycle controller.
// The MDU-related constants are present only when MC_CTRL_MDU_EN is defined.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_JR    = 6'b001000;
`ifdef MC_CTRL_MDU_EN
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
`endif

  typedef enum logic [2:0] {
    FETCH    = 3'd0,
    DECODE   = 3'd1,
    EXEC     = 3'd2,
    MEM      = 3'd3,
    WB       = 3'd4
`ifdef MC_CTRL_MDU_EN
    ,MDU_WAIT = 3'd5
`endif
  } state_e;

  localparam logic [1:0] NPC_PC4  = 2'b00;
  localparam logic [1:0] NPC_BR   = 2'b01;
  localparam logic [1:0] NPC_JUMP = 2'b10;
  localparam logic [1:0] NPC_REG  = 2'b11;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  localparam logic [1:0] M2R_ALU  = 2'b00;
  localparam logic [1:0] M2R_MEM  = 2'b01;
  localparam logic [1:0] M2R_PC4  = 2'b10;
`ifdef MC_CTRL_MDU_EN
  localparam logic [1:0] M2R_HILO = 2'b11;
`endif

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_OR   = 4'b0010;

  localparam logic [1:0] RD_RT    = 2'b00;
  localparam logic [1:0] RD_RD    = 2'b01;
  localparam logic [1:0] RD_R31   = 2'b10;

`ifdef MC_CTRL_MDU_EN
  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_DIV   = 2'b01;
`endif

  localparam int unsigned CNT_W = 6;

  // One-hot instruction class; all-zero means an unknown encoding.
  typedef struct packed {
    logic add;
    logic sub;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic jal;
    logic jr;
`ifdef MC_CTRL_MDU_EN
    logic mult;
    logic div;
    logic mfhi;
    logic mflo;
`endif
  } instr_cls_t;

  localparam int unsigned CLS_W = $bits(instr_cls_t);

endpackage

// File: rtl/mc_ctrl_dec.sv
// Combinational op/funct decoder producing the one-hot instruction class.
// MDU encodings decode only when MC_CTRL_MDU_EN is defined.
module mc_ctrl_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  output logic [CLS_W-1:0] cls
);

  instr_cls_t c;

  always_comb begin
    c = '0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  c.add  = 1'b1;
          FN_SUB:  c.sub  = 1'b1;
          FN_JR:   c.jr   = 1'b1;
`ifdef MC_CTRL_MDU_EN
          FN_MULT: c.mult = 1'b1;
          FN_DIV:  c.div  = 1'b1;
          FN_MFHI: c.mfhi = 1'b1;
          FN_MFLO: c.mflo = 1'b1;
`endif
          default: ;
        endcase
      end
      OP_ORI:  c.ori = 1'b1;
      OP_LUI:  c.lui = 1'b1;
      OP_LW:   c.lw  = 1'b1;
      OP_SW:   c.sw  = 1'b1;
      OP_BEQ:  c.beq = 1'b1;
      OP_JAL:  c.jal = 1'b1;
      default: ;
    endcase
  end

  assign cls = c;

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle controller FSM: FETCH/DECODE/EXEC/MEM/WB plus optional MDU wait.
// Define MC_CTRL_MDU_EN to enable mult/div/mfhi/mflo, MDU_WAIT and the wait counter.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       instr_vld,
  input  logic       mem_rdy,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic [1:0] RegDst,
  output logic       ALUSrc,
  output logic [1:0] MemtoReg,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic [1:0] nPC_sel,
  output logic [3:0] ALUOp,
  output logic [1:0] ExtOp,
  output logic       md_start,
  output logic [1:0] md_op,
  output logic       hilo_sel,
  output logic       busy
);

  instr_cls_t cls;
  state_e     state_q, state_d;

`ifdef MC_CTRL_MDU_EN
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  mc_ctrl_dec u_dec (
    .op    (op),
    .funct (funct),
    .cls   (cls)
  );

  always_comb begin
    state_d  = state_q;
`ifdef MC_CTRL_MDU_EN
    cnt_d    = cnt_q;
`endif
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    md_start = 1'b0;
    busy     = 1'b0;
    nPC_sel  = NPC_PC4;
    case (state_q)
      FETCH: begin
        // Reset holds the state in FETCH; gating keeps the fetch strobes quiet meanwhile.
        if (instr_vld && rst_n) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (cls.jal) begin
          PCWrite = 1'b1;
          nPC_sel = NPC_JUMP;
          state_d = WB;
        end else if (cls.jr) begin
          PCWrite = 1'b1;
          nPC_sel = NPC_REG;
          state_d = FETCH;
        end else if (cls == '0) begin
          state_d = FETCH;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cls.beq) begin
          PCWrite = zero;
          nPC_sel = NPC_BR;
          state_d = FETCH;
        end else if (cls.lw || cls.sw) begin
          state_d = MEM;
`ifdef MC_CTRL_MDU_EN
        end else if (cls.mult || cls.div) begin
          md_start = 1'b1;
          cnt_d    = cls.mult ? MULT_LOAD : DIV_LOAD;
          state_d  = MDU_WAIT;
`endif
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        MemRead  = cls.lw;
        MemWrite = cls.sw;
        if (mem_rdy) state_d = cls.lw ? WB : FETCH;
      end
      WB: begin
        RegWrite = 1'b1;
        state_d  = FETCH;
      end
`ifdef MC_CTRL_MDU_EN
      MDU_WAIT: begin
        busy = 1'b1;
        if (cnt_q == '0) state_d = FETCH;
        else             cnt_d   = cnt_q - 1'b1;
      end
`endif
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    ALUSrc = cls.ori | cls.lw | cls.sw | cls.lui;
    if (cls.sub || cls.beq) ALUOp = ALU_SUB;
    else if (cls.ori)       ALUOp = ALU_OR;
    else                    ALUOp = ALU_ADD;
    if (cls.lw || cls.sw || cls.beq) ExtOp = EXT_SIGN;
    else if (cls.lui)                ExtOp = EXT_LUI;
    else                             ExtOp = EXT_ZERO;
    RegDst   = RD_RT;
    MemtoReg = M2R_ALU;
    if (cls.jal) begin
      RegDst   = RD_R31;
      MemtoReg = M2R_PC4;
    end else if (cls.add || cls.sub) begin
      RegDst   = RD_RD;
    end else if (cls.lw) begin
      MemtoReg = M2R_MEM;
    end
`ifdef MC_CTRL_MDU_EN
    if (cls.mfhi || cls.mflo) begin
      RegDst   = RD_RD;
      MemtoReg = M2R_HILO;
    end
    md_op    = cls.div ? MD_DIV : MD_MULT;
    hilo_sel = cls.mflo;
`else
    md_op    = '0;
    hilo_sel = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
`ifdef MC_CTRL_MDU_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
`ifdef MC_CTRL_MDU_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, meaning the number of cycles spent in the MDU_WAIT state for mult (legal range 1..63).
REQ-002 SHALL have parameter DIV_CYCLES, default 10, meaning the number of cycles spent in the MDU_WAIT state for div (legal range 1..63).
REQ-003 Ports are as follows; clk and rst_n are listed first:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- op  in  6  opcode field of the held IR.
- funct  in  6  funct field of the held IR.
- zero  in  1  ALU equality flag.
- instr_vld  in  1  instruction-memory data valid.
- mem_rdy  in  1  data-memory access complete.
- PCWrite  out  1  PC load strobe.
- IRWrite  out  1  IR load strobe.
- RegDst  out  2  register destination select: 00 rt, 01 rd, 10 $31.
- ALUSrc  out  1  ALU B operand select: 1 = extended immediate.
- MemtoReg  out  2  write-back source: 00 ALU, 01 mem, 10 PC+4, 11 HI/LO.
- RegWrite  out  1  register-file write enable.
- MemRead  out  1  data-memory read request.
- MemWrite  out  1  data-memory write request.
- nPC_sel  out  2  next-PC select: 00 PC+4, 01 branch, 10 jump, 11 register.
- ALUOp  out  4  ALU operation: 0000 add, 0001 sub, 0010 or.
- ExtOp  out  2  extender mode: 00 zero, 01 sign, 10 lui.
- md_start  out  1  one-cycle MDU start pulse.
- md_op  out  2  MDU operation: 00 mult, 01 div.
- hilo_sel  out  1  HI/LO read select: 0 HI, 1 LO.
- busy  out  1  MDU wait in progress.

Function
REQ-004 The FSM SHALL have exactly these states: FETCH, DECODE, EXEC, MEM, WB, MDU_WAIT; all outputs are decoded from the current state plus op/funct.
REQ-005 FETCH: stay in FETCH while instr_vld=0; when instr_vld=1, assert IRWrite=1 and PCWrite=1 with nPC_sel=00 for that cycle, then go to DECODE.
REQ-006 DECODE: jal asserts PCWrite with nPC_sel=10 and goes to WB; jr asserts PCWrite with nPC_sel=11 and goes to FETCH; unknown encodings go to FETCH with no strobes; all other instructions go to EXEC.
REQ-007 EXEC, per instruction class:
- add, sub, ori, lui, mfhi, mflo go to WB.
- lw and sw go to MEM.
- beq asserts PCWrite=zero with nPC_sel=01 and goes to FETCH.
- mult and div pulse md_start for one cycle, load the counter with (MULT_CYCLES or DIV_CYCLES) minus 1, and go to MDU_WAIT.
REQ-008 MEM: hold MemRead (lw) or MemWrite (sw) for as long as mem_rdy=0; on the cycle mem_rdy=1, sw goes to FETCH and lw goes to WB; a mem_rdy already high on entry completes in the first cycle.
REQ-009 WB: assert RegWrite=1 for exactly one cycle with the RegDst/MemtoReg pair (01/00 R-type, 00/00 ori and lui, 00/01 lw, 10/10 jal, 01/11 mfhi and mflo), then go to FETCH.
REQ-010 MDU_WAIT: busy=1; the counter decrements each cycle; when the counter is 0, go to FETCH; counter width is 6 bits.
REQ-011 Decode rules for the datapath selects:
- ALUSrc=1 for ori, lw, sw, lui.
- ALUOp=0001 for sub and beq; ALUOp=0010 for ori; otherwise 0000.
- ExtOp=01 for lw, sw, beq; ExtOp=10 for lui; otherwise 00.
REQ-012 Strobe outputs (PCWrite, IRWrite, RegWrite, MemRead, MemWrite, md_start) SHALL be 0 in every state where the rules above do not assert them.
REQ-013 Cycle counts with instr_vld and mem_rdy tied high: jr 2, beq 3, jal 3, sw 4, R-type and immediate 4, lw 5, mult 3+MULT_CYCLES, div 3+DIV_CYCLES.

Reset
REQ-014 When rst_n=0 (asynchronous), the FSM SHALL go to FETCH, the counter SHALL clear to 0, and all strobes and busy SHALL be 0; an instruction in flight, including an MDU wait, is abandoned without a write.
REQ-015 The first state evaluated after rst_n rises SHALL be FETCH.

Configuration
REQ-016 Macro MC_CTRL_MDU_EN:
- Defined: mult (000000/011000), div (000000/011010), mfhi (000000/010000) and mflo (000000/010010) behave as specified above.
- Undefined: those four encodings decode as unknown instructions; md_start, busy, md_op and hilo_sel are tied to 0; MDU_WAIT and the counter are removed.

Structure
REQ-017 Opcode and funct constants, the state enum, and the nPC_sel/ExtOp/MemtoReg/ALUOp encodings SHALL reside in package mc_ctrl_pkg.
REQ-018 A combinational sub-module mc_ctrl_dec SHALL map op/funct to a one-hot instruction class; mc_ctrl holds only the FSM and the counter.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- add (op 000000, funct 100000), handshakes tied high -> states F,D,E,W; RegWrite=1 only in cycle 4, with RegDst=01 and MemtoReg=00.
- lw with mem_rdy low for 3 cycles -> MemRead high for 4 cycles, then WB with MemtoReg=01; total 8 cycles.
- beq with zero=1, then with zero=0 -> PCWrite=1 / nPC_sel=01 in EXEC, then PCWrite=0; both return to FETCH after 3 cycles.
- mult with MULT_CYCLES=5 -> md_start high for 1 cycle, busy high for 5 cycles, FETCH on cycle 9; with the macro undefined -> behaves as a no-op.
- rst_n pulsed low mid MDU_WAIT and mid MEM -> immediate FETCH, with busy, MemRead and MemWrite equal to 0 without waiting for a clock edge.
- jal then jr -> jal: PCWrite with nPC_sel=10 in DECODE, then RegWrite with RegDst=10 and MemtoReg=10; jr: nPC_sel=11, done in 2 cycles.
